mips_harvard_lsu: RTL and testbench

Parametrised load/store unit for the Harvard MIPS core. It sits between the execute stage and the data-memory port.
- Converts MIPS load/store requests (LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW) into word-aligned memory transactions.
- Supports variable-latency memory with a waitrequest stall and a configurable read latency.
- Supports memories without byte enables, using read-modify-write for sub-word stores.
- Returns sign/zero-extended or merged load data with a one-cycle valid pulse.

---
 rtl/mips_harvard_lsu.sv | 227 ++++++++++++++++++++++
 tb/tb_mips_harvard_lsu.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_harvard_lsu.sv
// mips_harvard_lsu: load/store unit between the execute stage and the data-memory port.
// Converts MIPS byte/half/word/unaligned loads and stores into word-aligned memory
// transactions. Handles waitrequest stalls, a fixed read latency and, optionally,
// read-modify-write for sub-word stores on memories without byte enables.
// Ports:
//   clk, resetl (async, active low), clk_enable (freezes everything when low)
//   req_*   : request handshake from execute (op, byte address, store data, old rt)
//   resp_*  : one-cycle response pulse with formatted load data and error flag
//   data_*  : word-aligned memory command port with waitrequest
module mips_harvard_lsu #(
    parameter int DATA_LATENCY   = 0,
    parameter bit USE_BYTEENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        resetl,
    input  logic        clk_enable,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt_old,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [3:0]  data_byteenable,
    output logic [31:0] data_writedata,
    input  logic [31:0] data_readdata,
    input  logic        data_waitrequest
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD      = 3'd1;
    localparam logic [2:0] S_LAT     = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_RMW_RD  = 3'd4;
    localparam logic [2:0] S_RMW_LAT = 3'd5;
    localparam logic [2:0] S_RMW_WR  = 3'd6;
    localparam logic [2:0] S_RESP    = 3'd7;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LWL = 4'd5;
    localparam logic [3:0] OP_LWR = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    localparam int CW = (DATA_LATENCY > 1) ? $clog2(DATA_LATENCY) : 1;
    // Counter is loaded with LATENCY-1 so that LAT lasts exactly DATA_LATENCY cycles.
    localparam logic [CW-1:0] LAT_LOAD = (DATA_LATENCY > 0) ? CW'(DATA_LATENCY - 1) : '0;

    logic [2:0]    state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rt_q, rt_d;
    logic [31:0]   word_q, word_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic op_bad(input logic [3:0] op, input logic [1:0] a);
        case (op)
            OP_LB, OP_LBU, OP_LWL, OP_LWR, OP_SB: op_bad = 1'b0;
            OP_LH, OP_LHU, OP_SH:                 op_bad = a[0];
            OP_LW, OP_SW:                         op_bad = (a != 2'b00);
            default:                              op_bad = 1'b1;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        op_is_load = (op <= OP_LWR);
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rt_d    = rt_q;
        word_d  = word_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rt_d    = req_rt_old;
                    err_d   = op_bad(req_op, req_addr[1:0]);
                    if (err_d)
                        state_d = S_RESP;
                    else if (op_is_load(req_op))
                        state_d = S_RD;
                    else if (!USE_BYTEENABLE && (req_op == OP_SB || req_op == OP_SH))
                        state_d = S_RMW_RD;
                    else
                        state_d = S_WR;
                end
            end
            S_RD, S_RMW_RD: begin
                if (!data_waitrequest) begin
                    if (DATA_LATENCY == 0) begin
                        word_d  = data_readdata;
                        state_d = (state_q == S_RD) ? S_RESP : S_RMW_WR;
                    end else begin
                        cnt_d   = LAT_LOAD;
                        state_d = (state_q == S_RD) ? S_LAT : S_RMW_LAT;
                    end
                end
            end
            S_LAT, S_RMW_LAT: begin
                if (cnt_q == '0) begin
                    word_d  = data_readdata;
                    state_d = (state_q == S_LAT) ? S_RESP : S_RMW_WR;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WR, S_RMW_WR: begin
                if (!data_waitrequest)
                    state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rt_q    <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (clk_enable) begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rt_q    <= rt_d;
            word_q  <= word_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [3:0]  be_sub;
    logic [31:0] repl, lane_mask, load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        rd_active, wr_active;

    // Store lanes and replicated data.
    always_comb begin
        case (op_q)
            OP_SB:   begin be_sub = 4'b0001 << addr_q[1:0];              repl = {4{wdata_q[7:0]}};  end
            OP_SH:   begin be_sub = addr_q[1] ? 4'b1100 : 4'b0011;       repl = {2{wdata_q[15:0]}}; end
            default: begin be_sub = 4'b1111;                             repl = wdata_q;            end
        endcase
        lane_mask = {{8{be_sub[3]}}, {8{be_sub[2]}}, {8{be_sub[1]}}, {8{be_sub[0]}}};
    end

    // Load formatting. LWL places memory bytes 0..k at the top of rt; LWR places
    // memory bytes 0..k at the bottom; untouched bytes keep the old rt value.
    always_comb begin
        byte_sel  = 8'(word_q >> {addr_q[1:0], 3'b000});
        half_sel  = addr_q[1] ? word_q[31:16] : word_q[15:0];
        load_data = '0;
        case (op_q)
            OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: load_data = {24'h0, byte_sel};
            OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU: load_data = {16'h0, half_sel};
            OP_LW:  load_data = word_q;
            OP_LWL: begin
                case (addr_q[1:0])
                    2'd0:    load_data = {word_q[7:0],  rt_q[23:0]};
                    2'd1:    load_data = {word_q[15:0], rt_q[15:0]};
                    2'd2:    load_data = {word_q[23:0], rt_q[7:0]};
                    default: load_data = word_q;
                endcase
            end
            OP_LWR: begin
                case (addr_q[1:0])
                    2'd0:    load_data = {rt_q[31:8],  word_q[7:0]};
                    2'd1:    load_data = {rt_q[31:16], word_q[15:0]};
                    2'd2:    load_data = {rt_q[31:24], word_q[23:0]};
                    default: load_data = word_q;
                endcase
            end
            default: load_data = '0;
        endcase
    end

    always_comb begin
        rd_active       = (state_q == S_RD) || (state_q == S_RMW_RD);
        wr_active       = (state_q == S_WR) || (state_q == S_RMW_WR);
        data_read       = rd_active;
        data_write      = wr_active;
        data_address    = (rd_active || wr_active) ? {addr_q[31:2], 2'b00} : '0;
        data_byteenable = '0;
        data_writedata  = '0;
        if (rd_active || state_q == S_RMW_WR)
            data_byteenable = 4'b1111;
        else if (state_q == S_WR)
            data_byteenable = be_sub;
        if (state_q == S_WR)
            data_writedata = repl;
        else if (state_q == S_RMW_WR)
            data_writedata = (word_q & ~lane_mask) | (repl & lane_mask);
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !err_q && op_is_load(op_q)) ? load_data : '0;
    end

endmodule

// File: tb/tb_mips_harvard_lsu.sv
// tb_mips_harvard_lsu: drives two configurations of mips_harvard_lsu
// (dut0: DATA_LATENCY=0, byte enables; dut1: DATA_LATENCY=2, read-modify-write)
// with directed and random requests and compares each transaction against a
// transaction-level reference model.
module tb_mips_harvard_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetl[2], clk_enable[2], req_valid[2], req_ready[2];
    logic [3:0]  req_op[2];
    logic [31:0] req_addr[2], req_wdata[2], req_rt_old[2];
    logic        resp_valid[2], resp_err[2];
    logic [31:0] resp_rdata[2], data_address[2], data_writedata[2], data_readdata[2];
    logic        data_read[2], data_write[2], data_waitrequest[2];
    logic [3:0]  data_byteenable[2];

    int n_checks = 0;
    int n_errors = 0;

    mips_harvard_lsu #(.DATA_LATENCY(0), .USE_BYTEENABLE(1'b1)) dut0 (
        .clk(clk), .resetl(resetl[0]), .clk_enable(clk_enable[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_rt_old(req_rt_old[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .data_address(data_address[0]), .data_read(data_read[0]), .data_write(data_write[0]),
        .data_byteenable(data_byteenable[0]), .data_writedata(data_writedata[0]),
        .data_readdata(data_readdata[0]), .data_waitrequest(data_waitrequest[0]));

    mips_harvard_lsu #(.DATA_LATENCY(2), .USE_BYTEENABLE(1'b0)) dut1 (
        .clk(clk), .resetl(resetl[1]), .clk_enable(clk_enable[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_rt_old(req_rt_old[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .data_address(data_address[1]), .data_read(data_read[1]), .data_write(data_write[1]),
        .data_byteenable(data_byteenable[1]), .data_writedata(data_writedata[1]),
        .data_readdata(data_readdata[1]), .data_waitrequest(data_waitrequest[1]));

    // Memory contents are a fixed function of the word address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w == 32'h100) return 32'h8899_AABB;
        if (w == 32'h200) return 32'h1122_3344;
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // dut0: combinational read. dut1: data valid exactly 2 enabled cycles after the read is taken.
    assign data_readdata[0] = data_read[0] ? memf(data_address[0]) : 32'hDEAD_BEEF;

    int          pipe_cnt1;
    logic [31:0] pipe_addr1;
    always @(posedge clk or negedge resetl[1]) begin
        if (!resetl[1]) begin
            pipe_cnt1 <= 0;
            pipe_addr1 <= '0;
        end else if (clk_enable[1]) begin
            if (data_read[1] && !data_waitrequest[1]) begin
                pipe_cnt1  <= 2;
                pipe_addr1 <= data_address[1];
            end else if (pipe_cnt1 != 0) begin
                pipe_cnt1 <= pipe_cnt1 - 1;
            end
        end
    end
    assign data_readdata[1] = (pipe_cnt1 == 1) ? memf(pipe_addr1) : 32'hDEAD_BEEF;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input int op);
        if (op == 2 || op == 3 || op == 9) return 2;
        if (op == 4 || op == 10) return 4;
        return 1;
    endfunction

    function automatic bit model_bad(input int op, input logic [31:0] addr);
        bit legal;
        legal = (op >= 0 && op <= 6) || (op >= 8 && op <= 10);
        return !legal || ((addr % op_size(op)) != 0);
    endfunction

    function automatic logic [31:0] model_load(input int op, input logic [31:0] addr,
                                              input logic [31:0] word, input logic [31:0] rt);
        int unsigned k, b, h, n;
        longint unsigned lowm, w64, r64;
        k = addr % 4;
        b = (word >> (8 * k)) & 32'hFF;
        h = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        n = 8 * (k + 1);
        w64 = word;
        r64 = rt;
        case (op)
            0: return 32'(int'(b) - ((b >= 128) ? 256 : 0));
            1: return b;
            2: return 32'(int'(h) - ((h >= 32768) ? 65536 : 0));
            3: return h;
            4: return word;
            5: begin
                lowm = (64'd1 << (32 - n)) - 1;
                return 32'(((w64 << (32 - n)) & 64'hFFFF_FFFF) | (r64 & lowm));
            end
            6: begin
                lowm = (64'd1 << n) - 1;
                return 32'((w64 & lowm) | (r64 & ~lowm & 64'hFFFF_FFFF));
            end
            default: return 0;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input int op, input logic [31:0] addr);
        return 4'(((1 << op_size(op)) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] model_repl(input int op, input logic [31:0] wd);
        if (op == 8) return (wd & 32'hFF) * 32'h0101_0101;
        if (op == 9) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    // ---------------- one transaction ----------------
    task automatic do_txn(input int d, input int op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rt,
                          input int waits, input int gap, input string tag);
        int lat, exp_cyc, exp_rd, exp_wr;
        bit bad, is_load, rmw;
        logic [31:0] exp_rdata, exp_wdata, mask, old;
        logic [3:0] exp_be;
        int left, rd_cyc, wr_cyc, resp_n, resp_cyc, rd_taken, gap_cnt, both, idle_bad;
        logic [31:0] got_rdata, got_raddr, got_waddr, got_wdata;
        logic [3:0] got_be;
        logic got_err, rdy_end;

        lat = (d == 1) ? 2 : 0;
        bad = model_bad(op, addr);
        is_load = (op <= 6);
        rmw = (d == 1) && (op == 8 || op == 9);
        exp_rdata = (!bad && is_load) ? model_load(op, addr, memf(addr), rt) : 32'h0;
        exp_be = (rmw || op == 10) ? 4'hF : model_be(op, addr);
        exp_wdata = model_repl(op, wdata);
        if (rmw) begin
            mask = 0;
            for (int i = 0; i < 4; i++)
                if ((model_be(op, addr) >> i) & 1) mask |= 32'hFF << (8 * i);
            old = memf(addr);
            exp_wdata = (old & ~mask) | (exp_wdata & mask);
        end
        if (bad)          begin exp_cyc = 1;                       exp_rd = 0;         exp_wr = 0;         end
        else if (is_load) begin exp_cyc = 2 + waits + lat + gap;   exp_rd = waits + 1; exp_wr = 0;         end
        else if (rmw)     begin exp_cyc = 3 + 2 * waits + lat;     exp_rd = waits + 1; exp_wr = waits + 1; end
        else              begin exp_cyc = 2 + waits;               exp_rd = 0;         exp_wr = waits + 1; end

        @(negedge clk);
        check32($sformatf("%s.ready", tag), 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1; req_op[d] = 4'(op); req_addr[d] = addr;
        req_wdata[d] = wdata; req_rt_old[d] = rt;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0; req_op[d] = 4'($urandom); req_addr[d] = $urandom;
        req_wdata[d] = $urandom; req_rt_old[d] = $urandom;

        left = waits; rd_cyc = 0; wr_cyc = 0; resp_n = 0; resp_cyc = -1; rd_taken = -1;
        gap_cnt = 0; both = 0; idle_bad = 0; rdy_end = 1'b0; got_err = 1'b0;
        got_rdata = 0; got_raddr = 0; got_waddr = 0; got_wdata = 0; got_be = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (gap > 0 && rd_taken >= 0 && cyc == rd_taken + 1) begin
                clk_enable[d] = 1'b0;
                gap_cnt = gap;
            end else if (gap_cnt > 0) begin
                gap_cnt--;
                if (gap_cnt == 0) clk_enable[d] = 1'b1;
            end
            if (data_read[d] && data_write[d]) both++;
            if (!data_read[d] && !data_write[d] &&
                (data_address[d] != 0 || data_byteenable[d] != 0 || data_writedata[d] != 0))
                idle_bad++;
            if (data_read[d]) rd_cyc++;
            if (data_write[d]) wr_cyc++;
            if (data_read[d] || data_write[d]) begin
                if (left > 0) begin
                    data_waitrequest[d] = 1'b1;
                    left--;
                end else begin
                    data_waitrequest[d] = 1'b0;
                    left = waits;
                    if (data_read[d]) begin rd_taken = cyc; got_raddr = data_address[d]; end
                    if (data_write[d]) begin
                        got_waddr = data_address[d]; got_be = data_byteenable[d];
                        got_wdata = data_writedata[d];
                    end
                end
            end else begin
                data_waitrequest[d] = 1'b0;
            end
            if (resp_valid[d]) begin
                resp_n++;
                if (resp_cyc < 0) begin
                    resp_cyc = cyc; got_rdata = resp_rdata[d]; got_err = resp_err[d];
                end
            end
            if (resp_cyc >= 0 && cyc >= resp_cyc + 2) begin
                rdy_end = req_ready[d];
                break;
            end
        end
        data_waitrequest[d] = 1'b0;
        clk_enable[d] = 1'b1;

        check32($sformatf("%s.resp_count", tag), resp_n, 1);
        check32($sformatf("%s.resp_cycle", tag), resp_cyc, exp_cyc);
        check32($sformatf("%s.err", tag), 32'(got_err), 32'(bad));
        check32($sformatf("%s.rdata", tag), got_rdata, exp_rdata);
        check32($sformatf("%s.read_cycles", tag), rd_cyc, exp_rd);
        check32($sformatf("%s.write_cycles", tag), wr_cyc, exp_wr);
        check32($sformatf("%s.rd_wr_both", tag), both, 0);
        check32($sformatf("%s.idle_bus", tag), idle_bad, 0);
        check32($sformatf("%s.ready_after", tag), 32'(rdy_end), 32'd1);
        if (exp_rd > 0)
            check32($sformatf("%s.raddr", tag), got_raddr, addr & 32'hFFFF_FFFC);
        if (exp_wr > 0) begin
            check32($sformatf("%s.waddr", tag), got_waddr, addr & 32'hFFFF_FFFC);
            check32($sformatf("%s.be", tag), 32'(got_be), 32'(exp_be));
            check32($sformatf("%s.wdata", tag), got_wdata, exp_wdata);
        end
    endtask

    // Reset while a read is stalled: everything clears at once, nothing follows.
    task automatic do_reset_mid(input int d);
        int seen;
        @(negedge clk);
        req_valid[d] = 1'b1; req_op[d] = 4'd0; req_addr[d] = 32'h101;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        @(negedge clk);
        data_waitrequest[d] = 1'b1;
        check32("rstmid.read_before", 32'(data_read[d]), 32'd1);
        @(negedge clk);
        resetl[d] = 1'b0;
        #1;
        check32("rstmid.ctrl", {26'h0, resp_valid[d], resp_err[d], data_read[d], data_write[d],
                                data_byteenable[d] != 0, req_ready[d]}, 32'h1);
        check32("rstmid.addr", data_address[d], 32'h0);
        check32("rstmid.wdata", data_writedata[d], 32'h0);
        check32("rstmid.rdata", resp_rdata[d], 32'h0);
        repeat (2) @(negedge clk);
        resetl[d] = 1'b1;
        data_waitrequest[d] = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid[d] || data_read[d] || data_write[d]) seen++;
        end
        check32("rstmid.no_resp", seen, 0);
        check32("rstmid.ready", 32'(req_ready[d]), 32'd1);
    endtask

    int legal_ops[10] = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10};

    initial begin
        for (int d = 0; d < 2; d++) begin
            resetl[d] = 1'b0; clk_enable[d] = 1'b1; req_valid[d] = 1'b0; req_op[d] = '0;
            req_addr[d] = '0; req_wdata[d] = '0; req_rt_old[d] = '0; data_waitrequest[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check32($sformatf("reset%0d.ready", d), 32'(req_ready[d]), 32'd1);
            check32($sformatf("reset%0d.ctrl", d),
                    {28'h0, resp_valid[d], resp_err[d], data_read[d], data_write[d]}, 32'h0);
            check32($sformatf("reset%0d.be", d), 32'(data_byteenable[d]), 32'h0);
            check32($sformatf("reset%0d.addr", d), data_address[d], 32'h0);
            check32($sformatf("reset%0d.wdata", d), data_writedata[d], 32'h0);
            check32($sformatf("reset%0d.rdata", d), resp_rdata[d], 32'h0);
        end
        resetl[0] = 1'b1;
        resetl[1] = 1'b1;

        // Directed cases.
        do_txn(0, 0, 32'h101, 32'h0, 32'h0, 0, 0, "lb_101");
        do_txn(1, 3, 32'h102, 32'h0, 32'h0, 3, 0, "lhu_102_wait3");
        do_txn(0, 9, 32'h106, 32'h1234, 32'h0, 0, 0, "sh_106");
        do_txn(1, 8, 32'h203, 32'hEE, 32'h0, 0, 0, "sb_203_rmw");
        do_txn(0, 4, 32'h102, 32'h0, 32'h0, 0, 0, "lw_misalign");
        do_txn(1, 7, 32'h100, 32'h0, 32'h0, 0, 0, "op7");
        do_txn(1, 4, 32'h100, 32'h0, 32'h0, 0, 5, "lw_ce_gap");
        do_txn(0, 5, 32'h101, 32'h0, 32'hCAFE_F00D, 1, 0, "lwl_101");
        do_txn(0, 6, 32'h102, 32'h0, 32'hCAFE_F00D, 0, 0, "lwr_102");
        do_reset_mid(0);

        // Random traffic on both configurations.
        for (int i = 0; i < 80; i++) begin
            int d, op;
            logic [31:0] a;
            d  = i % 2;
            op = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15))
                                             : legal_ops[$urandom_range(0, 9)];
            a  = $urandom_range(0, 1023);
            if ($urandom_range(0, 1) == 0) a &= 32'hFFFF_FFFC;
            do_txn(d, op, a, $urandom, $urandom, int'($urandom_range(0, 2)),
                   (d == 1 && op <= 6 && $urandom_range(0, 3) == 0) ? 3 : 0,
                   $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, limit 500000 time units");
        $fatal(1);
    end

endmodule
